// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the flexible synchronous FIFO.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int default_af(input int depth);
    return depth - 2;
  endfunction

  function automatic int default_ae(input int depth);
    return (depth > 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, status-flag and sticky-error control for sync_fifo_flex.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic                  i_err_clr,
  output logic                  o_wr_acc,
  output logic                  o_rd_acc,
  output logic [ADDR_WIDTH-1:0] o_wr_ptr,
  output logic [ADDR_WIDTH-1:0] o_rd_ptr,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

  if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
    $error("fifo_ctrl: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if ((DEPTH < 2) || ((1 << ADDR_WIDTH) < DEPTH)) begin : g_bad_depth
    $error("fifo_ctrl: DEPTH must be >= 2 and fit in ADDR_WIDTH pointer bits");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_empty, r_full, r_almost_empty, r_almost_full;
  logic                  r_overflow, r_underflow;
  logic                  w_wr_acc, w_rd_acc;
  logic [LW-1:0]         w_level_next;

  // Explicit wrap so non-power-of-two depths never see an unused slot.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
  endfunction

  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & ~r_empty;

  // Next occupancy; flags are derived from it so they never lag a cycle.
  always_comb begin
    w_level_next = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // Pointer, level, flag and sticky error state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr       <= PTR_ZERO;
      r_rd_ptr       <= PTR_ZERO;
      r_level        <= LVL_ZERO;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_level        <= w_level_next;
      r_empty        <= (w_level_next == LVL_ZERO);
      r_full         <= (w_level_next == LVL_FULL);
      r_almost_empty <= (w_level_next <= LVL_AE);
      r_almost_full  <= (w_level_next >= LVL_AF);
      r_overflow     <= (i_wr_en & r_full)  | (r_overflow  & ~i_err_clr);
      r_underflow    <= (i_rd_en & r_empty) | (r_underflow & ~i_err_clr);
    end
  end

  assign o_wr_acc       = w_wr_acc;
  assign o_rd_acc       = w_rd_acc;
  assign o_wr_ptr       = r_wr_ptr;
  assign o_rd_ptr       = r_rd_ptr;
  assign o_level        = r_level;
  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_almost_empty = r_almost_empty;
  assign o_almost_full  = r_almost_full;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with arbitrary depth, standard or fall-through read,
// threshold flags, occupancy count and sticky error flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DW         = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_THRESH  = default_af(DEPTH),
  parameter int AE_THRESH  = default_ae(DEPTH)
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                wr_en,
  input  logic [DW-1:0]       data_in,
  input  logic                rd_en,
  input  logic                err_clr,
  output logic [DW-1:0]       data_out,
  output logic                data_valid,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [ADDR_WIDTH:0] level,
  output logic                overflow,
  output logic                underflow
);

  logic                  w_wr_acc, w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_wr_ptr, w_rd_ptr;
  logic [DW-1:0]         r_mem [DEPTH];

  fifo_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ctrl (
    .clk            (clk),
    .sys_rst        (sys_rst),
    .i_wr_en        (wr_en),
    .i_rd_en        (rd_en),
    .i_err_clr      (err_clr),
    .o_wr_acc       (w_wr_acc),
    .o_rd_acc       (w_rd_acc),
    .o_wr_ptr       (w_wr_ptr),
    .o_rd_ptr       (w_rd_ptr),
    .o_level        (level),
    .o_empty        (empty),
    .o_full         (full),
    .o_almost_empty (almost_empty),
    .o_almost_full  (almost_full),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= data_in;
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is presented directly; zero while empty so reset output is clean.
    assign data_out   = empty ? {DW{1'b0}} : r_mem[w_rd_ptr];
    assign data_valid = ~empty;
  end else begin : g_std
    logic [DW-1:0] r_data_out;
    logic          r_data_valid;

    // One-cycle read register; data holds its last value between reads.
    always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_data_out   <= {DW{1'b0}};
        r_data_valid <= 1'b0;
      end else if (w_rd_acc) begin
        r_data_out   <= r_mem[w_rd_ptr];
        r_data_valid <= 1'b1;
      end else begin
        r_data_valid <= 1'b0;
      end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed, table-driven self-checking bench for sync_fifo_flex (DEPTH=6,
// one standard-mode instance and one fall-through instance).
module tb_sync_fifo_flex;

  logic       clk;
  logic       rst;
  logic       wr, rd, clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dvalid, emp, ful, aemp, afull, ovf, unf;
  logic [3:0] lvl;

  logic       f_wr, f_rd, f_clr;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       f_dvalid, f_emp, f_ful, f_aemp, f_afull, f_ovf, f_unf;
  logic [3:0] f_lvl;

  int n_chk;
  int n_fail;

  sync_fifo_flex #(.DW(8), .DEPTH(6), .ADDR_WIDTH(3), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) dut (
    .clk(clk), .sys_rst(rst), .wr_en(wr), .data_in(din), .rd_en(rd), .err_clr(clr),
    .data_out(dout), .data_valid(dvalid), .empty(emp), .full(ful),
    .almost_empty(aemp), .almost_full(afull), .level(lvl), .overflow(ovf), .underflow(unf)
  );

  sync_fifo_flex #(.DW(8), .DEPTH(6), .ADDR_WIDTH(3), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) dut_f (
    .clk(clk), .sys_rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd), .err_clr(f_clr),
    .data_out(f_dout), .data_valid(f_dvalid), .empty(f_emp), .full(f_ful),
    .almost_empty(f_aemp), .almost_full(f_afull), .level(f_lvl), .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {empty, full, almost_empty, almost_full, data_valid, overflow, underflow}
  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic       clr;
    logic [3:0] lvl;
    logic [6:0] flg;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input logic c,
                              input int l, input logic [6:0] f, input logic [7:0] o);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.clr = c; v.lvl = 4'(l); v.flg = f; v.dout = o;
    return v;
  endfunction

  function automatic logic [6:0] flags();
    return {emp, ful, aemp, afull, dvalid, ovf, unf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr = w; rd = r; din = d; clr = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic fstep(input logic w, input logic r, input logic [7:0] d);
    f_wr = w; f_rd = r; f_din = d;
    @(posedge clk);
    #1;
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
    f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_level", 32'(lvl), 32'd0);
    chk("reset_flags", 32'(flags()), 32'(7'b1010000));
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_f_valid", 32'(f_dvalid), 32'd0);
    chk("reset_f_dout", 32'(f_dout), 32'h00);

    // Fill to full, then overflow
    tbl.push_back(mk(1, 0, 8'h11, 0, 1, 7'b0010000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h12, 0, 2, 7'b0000000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h13, 0, 3, 7'b0000000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h14, 0, 4, 7'b0001000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h15, 0, 5, 7'b0001000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h16, 0, 6, 7'b0101000, 8'h00));
    tbl.push_back(mk(1, 0, 8'h17, 0, 6, 7'b0101010, 8'h00));
    // Drain, then underflow, then clear errors
    tbl.push_back(mk(0, 1, 8'h00, 0, 5, 7'b0001110, 8'h11));
    tbl.push_back(mk(0, 1, 8'h00, 0, 4, 7'b0001110, 8'h12));
    tbl.push_back(mk(0, 1, 8'h00, 0, 3, 7'b0000110, 8'h13));
    tbl.push_back(mk(0, 1, 8'h00, 0, 2, 7'b0000110, 8'h14));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 7'b0010110, 8'h15));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 7'b1010110, 8'h16));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 7'b1010011, 8'h16));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 7'b1010000, 8'h16));
    // Wrap-around: 4 in, 4 out, then 5 across the 5->0 boundary
    tbl.push_back(mk(1, 0, 8'h21, 0, 1, 7'b0010000, 8'h16));
    tbl.push_back(mk(1, 0, 8'h22, 0, 2, 7'b0000000, 8'h16));
    tbl.push_back(mk(1, 0, 8'h23, 0, 3, 7'b0000000, 8'h16));
    tbl.push_back(mk(1, 0, 8'h24, 0, 4, 7'b0001000, 8'h16));
    tbl.push_back(mk(0, 1, 8'h00, 0, 3, 7'b0000100, 8'h21));
    tbl.push_back(mk(0, 1, 8'h00, 0, 2, 7'b0000100, 8'h22));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 7'b0010100, 8'h23));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 7'b1010100, 8'h24));
    tbl.push_back(mk(1, 0, 8'hA0, 0, 1, 7'b0010000, 8'h24));
    tbl.push_back(mk(1, 0, 8'hA1, 0, 2, 7'b0000000, 8'h24));
    tbl.push_back(mk(1, 0, 8'hA2, 0, 3, 7'b0000000, 8'h24));
    tbl.push_back(mk(1, 0, 8'hA3, 0, 4, 7'b0001000, 8'h24));
    tbl.push_back(mk(1, 0, 8'hA4, 0, 5, 7'b0001000, 8'h24));
    tbl.push_back(mk(0, 1, 8'h00, 0, 4, 7'b0001100, 8'hA0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 3, 7'b0000100, 8'hA1));
    tbl.push_back(mk(0, 1, 8'h00, 0, 2, 7'b0000100, 8'hA2));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 7'b0010100, 8'hA3));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 7'b1010100, 8'hA4));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr);
      chk($sformatf("vec%0d_level", i), 32'(lvl), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tbl[i].flg));
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
    end

    // Simultaneous read/write at level 3 keeps level and order
    step(1, 0, 8'hB0, 0);
    step(1, 0, 8'hB1, 0);
    step(1, 0, 8'hB2, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(8'hC0 + i), 0);
      chk($sformatf("rw%0d_level", i), 32'(lvl), 32'd3);
      chk($sformatf("rw%0d_dout", i), 32'(dout), (i < 3) ? 32'(8'hB0 + i) : 32'(8'hC0 + i - 3));
      chk($sformatf("rw%0d_valid", i), 32'(dvalid), 32'd1);
    end
    step(1, 0, 8'hD0, 0);
    step(1, 0, 8'hD1, 0);
    step(1, 0, 8'hD2, 0);
    chk("fill_full", 32'(ful), 32'd1);
    // Full with both requests: read wins, write rejected
    step(1, 1, 8'hE0, 0);
    chk("full_rw_level", 32'(lvl), 32'd5);
    chk("full_rw_dout", 32'(dout), 32'hC7);
    chk("full_rw_ovf", 32'(ovf), 32'd1);
    chk("full_rw_full", 32'(ful), 32'd0);
    step(0, 0, 8'h00, 1);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // err_clr coinciding with a new overflow: set wins
    step(1, 0, 8'hD3, 0);
    step(1, 0, 8'hEE, 1);
    chk("clr_vs_set_ovf", 32'(ovf), 32'd1);
    chk("clr_vs_set_level", 32'(lvl), 32'd6);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    chk("pre_rst_level", 32'(lvl), 32'd4);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);

    // Asynchronous reset mid-cycle, away from any clock edge
    #1 rst = 1'b1;
    #2;
    chk("async_rst_level", 32'(lvl), 32'd0);
    chk("async_rst_flags", 32'(flags()), 32'(7'b1010000));
    chk("async_rst_dout", 32'(dout), 32'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 0, 8'h77, 0);
    step(0, 1, 8'h00, 0);
    chk("post_rst_dout", 32'(dout), 32'h77);
    chk("post_rst_empty", 32'(emp), 32'd1);

    // Fall-through instance
    fstep(1, 0, 8'h5A);
    chk("fwft_dout", 32'(f_dout), 32'h5A);
    chk("fwft_valid", 32'(f_dvalid), 32'd1);
    fstep(0, 1, 8'h00);
    chk("fwft_pop_empty", 32'(f_emp), 32'd1);
    chk("fwft_pop_valid", 32'(f_dvalid), 32'd0);
    fstep(1, 0, 8'h61);
    fstep(1, 0, 8'h62);
    chk("fwft_head", 32'(f_dout), 32'h61);
    fstep(0, 1, 8'h00);
    chk("fwft_next", 32'(f_dout), 32'h62);
    chk("fwft_next_level", 32'(f_lvl), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised successor to the team's basic synchronous FIFO, used as the standard buffer between matrix-engine stages and the RSA datapath. Supports arbitrary (non-power-of-two) depth and a standard or first-word-fall-through read mode. Adds registered almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. Single clock domain, no CDC.

Parameters:
DW, 8, data width in bits
DEPTH, 8, number of entries; any integer >= 2
ADDR_WIDTH, 3, pointer width; 2^ADDR_WIDTH >= DEPTH
FWFT, 0, 0 = standard read with 1-cycle latency; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  system clock, rising edge
sys_rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
data_in  in  DW  write data
rd_en  in  1  read request; in FWFT mode, this is the pop/ack of the head word
err_clr  in  1  synchronous clear of the sticky error flags
data_out  out  DW  read data
data_valid  out  1  data_out holds a valid word
empty  out  1  level == 0
full  out  1  level == DEPTH
almost_empty  out  1  level <= AE_THRESH
almost_full  out  1  level >= AF_THRESH
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset: clock is clk. Reset is asynchronous and active-high on sys_rst.
- Reset values:
  - empty=1, full=0, almost_empty=1, almost_full=0, level=0
  - data_out=0, data_valid=0, overflow=0, underflow=0
  - both pointers reset to 0
  - storage array is not reset
- Reset asserted mid-operation discards all contents immediately. The first write after reset release is stored at entry 0.
- Accept rules, evaluated on registered flags:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Full with simultaneous wr_en and rd_en: read accepted, write rejected, overflow set. No write-through.
- Empty with simultaneous wr_en and rd_en: write accepted, read rejected, underflow set.
- Pointers increment on accept and wrap from DEPTH-1 to 0 explicitly (no reliance on power-of-two rollover).
- level next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- All flags are registered and computed from the next level. They are exact in the cycle after the causing edge, with no 1-cycle lag.
- FWFT=0 (standard mode):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 on the next edge.
  - Otherwise data_valid <= 0 and data_out holds its last value (it is not zeroed).
  - Read latency is 1 cycle.
- FWFT=1 (fall-through mode):
  - data_out = mem[rd_ptr] and data_valid = ~empty.
  - A word written into an empty FIFO appears on data_out 1 cycle after its write edge.
  - rd_acc advances to the next word, which is visible in the following cycle.
- Storage write happens on wr_acc. A read of the same entry in the same cycle returns the old content; this is only possible when full, with write blocked.
- Sticky error flags:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty.
  - Both flags are cleared by err_clr. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- Thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH. Elaboration-time check: $error if violated.

Decomposition:
- Shared package fifo_pkg:
  - clog2 helper function
  - FWFT_OFF/FWFT_ON mode constants
  - default threshold expressions
- One natural sub-module: fifo_ctrl, holding pointers, level, flags and error logic. The top level instantiates fifo_ctrl plus the storage array and the read-mode output stage.

Test Plan:
Common configuration unless noted: DW=8, DEPTH=6, FWFT=0.
1. Reset, then write 0x11..0x16 on 6 consecutive cycles -> level counts 1..6; full=1 after the 6th edge; almost_full=1 once level=4; a 7th write sets overflow=1 while level stays 6.
2. From full, read 6 times -> data_out 0x11..0x16, each one cycle after rd_en with data_valid pulsing; empty=1 after the last read; a further rd_en sets underflow=1 and data_out holds 0x16.
3. Wrap-around: 4 writes, 4 reads, then 5 writes of 0xA0..0xA4 and 5 reads -> output order 0xA0..0xA4 is preserved across the pointer wrap at entry 5→0.
4. Simultaneous wr_en and rd_en at level 3 for 10 cycles -> level stays 3 and data stays in order; at level 6 (full) with both asserted -> read accepted, write rejected, level=5, overflow=1.
5. FWFT=1: write 0x5A into the empty FIFO -> data_out=0x5A and data_valid=1 in the next cycle; rd_en pop -> empty=1 and data_valid=0 in the next cycle.
6. Assert sys_rst asynchronously mid-stream at level 4 with overflow=1 -> all outputs take their reset values without waiting for a clock edge; err_clr with a concurrent overflow event -> overflow remains 1.
